// File: rtl/alu_decode_exec.sv
// alu_decode_exec: EX-stage ALU. It decodes ALUOp/funct3/funct7, executes the operation and
// registers the result behind valid/ready handshakes. Single-cycle ops (add/sub/logic/shift/
// slt/mul) complete in one cycle. Divide/remainder uses an iterative radix-2 restoring divider
// that produces one quotient bit per cycle.
//
// Build option: define ALU_DIV_EN to include the divider. Without it, divide-group encodings
// are reported as illegal and busy is tied low.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake (ALUOp, funct3, funct7, a, b)
//   out_valid/out_ready result handshake; result, zero and illegal are held while stalled
//   busy                divider is iterating
module alu_decode_exec #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);
    localparam int unsigned ShW = $clog2(XLEN);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StDone = 2'd1;
`ifdef ALU_DIV_EN
    localparam logic [1:0] StDiv  = 2'd2;
`endif

    localparam logic [3:0] OpIll  = 4'd0;
    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpSub  = 4'd2;
    localparam logic [3:0] OpSll  = 4'd3;
    localparam logic [3:0] OpSlt  = 4'd4;
    localparam logic [3:0] OpSltu = 4'd5;
    localparam logic [3:0] OpXor  = 4'd6;
    localparam logic [3:0] OpSrl  = 4'd7;
    localparam logic [3:0] OpSra  = 4'd8;
    localparam logic [3:0] OpOr   = 4'd9;
    localparam logic [3:0] OpAnd  = 4'd10;
    localparam logic [3:0] OpMul  = 4'd11;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OpDiv  = 4'd12;
`endif

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      op;
    logic [XLEN-1:0] alu_res;
    logic [ShW-1:0]  shamt;
    logic            accept;

    assign shamt     = b[ShW-1:0];
    assign out_valid = (state_q == StDone);
    // A stalled result frees the unit in the same cycle the consumer takes it.
    assign in_ready  = (state_q == StIdle) | (out_valid & out_ready);
    assign accept    = in_valid & in_ready;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    // Decode
    always_comb begin
        op = OpIll;
        case (ALUOp)
            2'b00: op = OpAdd;
            2'b01: op = OpSub;
            2'b10: begin
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  op = OpAdd;
                            3'b001:  op = OpSll;
                            3'b010:  op = OpSlt;
                            3'b011:  op = OpSltu;
                            3'b100:  op = OpXor;
                            3'b101:  op = OpSrl;
                            3'b110:  op = OpOr;
                            default: op = OpAnd;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      op = OpSub;
                        else if (funct3 == 3'b101) op = OpSra;
                    end
                    7'b0000001: begin
                        // funct3 001..011 (mulh variants) stay illegal.
                        if (funct3 == 3'b000) op = OpMul;
`ifdef ALU_DIV_EN
                        else if (funct3[2]) op = OpDiv;
`endif
                    end
                    default: op = OpIll;
                endcase
            end
            default: begin
                case (funct3)
                    3'b000: op = OpAdd;
                    3'b001: if (funct7 == 7'b0000000) op = OpSll;
                    3'b010: op = OpSlt;
                    3'b011: op = OpSltu;
                    3'b100: op = OpXor;
                    3'b101: begin
                        if (funct7 == 7'b0000000)      op = OpSrl;
                        else if (funct7 == 7'b0100000) op = OpSra;
                    end
                    3'b110:  op = OpOr;
                    default: op = OpAnd;
                endcase
            end
        endcase
    end

    // Single-cycle datapath
    always_comb begin
        alu_res = '0;
        case (op)
            OpAdd:   alu_res = a + b;
            OpSub:   alu_res = a - b;
            OpSll:   alu_res = a << shamt;
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, a < b};
            OpXor:   alu_res = a ^ b;
            OpSrl:   alu_res = a >> shamt;
            OpSra:   alu_res = $signed(a) >>> shamt;
            OpOr:    alu_res = a | b;
            OpAnd:   alu_res = a & b;
            OpMul:   alu_res = a * b;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_DIV_EN
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [ShW-1:0]  cnt_q, cnt_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d, remop_q, remop_d;
    logic [XLEN:0]   div_tmp, div_diff;
    logic [XLEN-1:0] step_quo, step_rem, fin_quo, fin_rem;
    logic            a_neg, b_neg;

    assign busy  = (state_q == StDiv);
    // funct3[0] clear selects the signed forms (div, rem).
    assign a_neg = ~funct3[0] & a[XLEN-1];
    assign b_neg = ~funct3[0] & b[XLEN-1];

    // One restoring step on magnitudes; sign fix-up applies to the final step's output.
    always_comb begin
        div_tmp  = {rem_q, quo_q[XLEN-1]};
        div_diff = div_tmp - {1'b0, dvs_q};
        if (!div_diff[XLEN]) begin
            step_rem = div_diff[XLEN-1:0];
            step_quo = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            step_rem = div_tmp[XLEN-1:0];
            step_quo = {quo_q[XLEN-2:0], 1'b0};
        end
        fin_quo = qneg_q ? -step_quo : step_quo;
        fin_rem = rneg_q ? -step_rem : step_rem;
    end
`else
    assign busy = 1'b0;
`endif

    // Control and result registers
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifdef ALU_DIV_EN
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        remop_d   = remop_q;
`endif
        case (state_q)
`ifdef ALU_DIV_EN
            StDiv: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ShW'(XLEN - 1)) begin
                    result_d  = remop_q ? fin_rem : fin_quo;
                    zero_d    = (result_d == '0);
                    illegal_d = 1'b0;
                    state_d   = StDone;
                end
            end
`endif
            default: begin
                if (out_valid && out_ready) state_d = StIdle;
                if (accept) begin
`ifdef ALU_DIV_EN
                    if (op == OpDiv) begin
                        quo_d   = a_neg ? -a : a;
                        dvs_d   = b_neg ? -b : b;
                        rem_d   = '0;
                        cnt_d   = '0;
                        // Divide by zero keeps the all-ones quotient, so never negate it.
                        qneg_d  = (a_neg ^ b_neg) & (b != '0);
                        rneg_d  = a_neg;
                        remop_d = funct3[1];
                        state_d = StDiv;
                    end else
`endif
                    begin
                        result_d  = (op == OpIll) ? '0 : alu_res;
                        zero_d    = (result_d == '0);
                        illegal_d = (op == OpIll);
                        state_d   = StDone;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
`ifdef ALU_DIV_EN
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            remop_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifdef ALU_DIV_EN
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            remop_q   <= remop_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_decode_exec.sv
// Scoreboard bench for alu_decode_exec (XLEN=32). Stimulus pushes expected {illegal, result}
// on each accepted operation; a negedge monitor pops and compares on every output handshake.
module tb_alu_decode_exec;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [32:0] exp_q[$];
    string       name_q[$];
    logic [32:0] mon_e;
    string       mon_n;

`ifdef ALU_DIV_EN
    localparam int DivCycles = 32;
`else
    localparam int DivCycles = 0;
`endif

    alu_decode_exec #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ALUOp    (ALUOp),
        .funct3   (funct3),
        .funct7   (funct7),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .illegal  (illegal),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got result=%h illegal=%b with nothing pending",
                         result, illegal);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (result !== mon_e[31:0] || illegal !== mon_e[32] ||
                    zero !== (mon_e[31:0] == 32'h0)) begin
                    errors++;
                    $display("FAIL %s: got result=%h zero=%b illegal=%b, expected result=%h zero=%b illegal=%b",
                             mon_n, result, zero, illegal, mon_e[31:0], (mon_e[31:0] == 32'h0),
                             mon_e[32]);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] eres,
                         input logic eill, input string name, output int waited);
        ALUOp    = op;
        funct3   = f3;
        funct7   = f7;
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: in_ready stayed 0, expected 1 within 200 cycles", name);
        end else begin
            exp_q.push_back({eill, eres});
            name_q.push_back(name);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic alu(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] eres,
                       input logic eill, input string name);
        int w;
        issue(op, f3, f7, ia, ib, eres, eill, name, w);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Divide-group op: checks the result via the scoreboard and the number of busy cycles.
    task automatic div_op(input logic [2:0] f3, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] eres, input string name);
        int w;
        int n;
        int nbusy;
        logic rdy_bad;
`ifdef ALU_DIV_EN
        issue(2'b10, f3, 7'b0000001, ia, ib, eres, 1'b0, name, w);
`else
        issue(2'b10, f3, 7'b0000001, ia, ib, 32'h0, 1'b1, name, w);
`endif
        n = 0;
        nbusy = 0;
        rdy_bad = 1'b0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            if (busy) nbusy++;
            if (busy && in_ready) rdy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk({name, "_busy_cycles"}, nbusy, DivCycles);
        chk({name, "_in_ready_while_busy"}, {31'b0, rdy_bad}, 32'h0);
        settle();
    endtask

    initial begin
        int w;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ALUOp     = 2'b00;
        funct3    = 3'b000;
        funct7    = 7'b0;
        a         = 32'h0;
        b         = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_result", result, 32'h0);
        chk("reset_zero", {31'b0, zero}, 32'h1);
        chk("reset_illegal", {31'b0, illegal}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
        settle();

        // Basic add with 1-cycle latency
        alu(2'b10, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd12, 1'b0, "add_r");
        @(negedge clk);
        chk("add_latency_out_valid", {31'b0, out_valid}, 32'h1);
        settle();

        // Back-to-back single-cycle ops
        alu(2'b10, 3'b101, 7'b0100000, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, "sra_r");
        alu(2'b10, 3'b101, 7'b0000000, 32'h80000000, 32'd4, 32'h08000000, 1'b0, "srl_r");
        alu(2'b01, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, "sub_aluop01");
        alu(2'b00, 3'b000, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, "add_aluop00_zero");
        alu(2'b10, 3'b000, 7'b0100000, 32'd9, 32'd9, 32'h0, 1'b0, "sub_r_zero");
        alu(2'b10, 3'b001, 7'b0000000, 32'd1, 32'd31, 32'h80000000, 1'b0, "sll_31");
        alu(2'b10, 3'b001, 7'b0000000, 32'd1, 32'h21, 32'h2, 1'b0, "sll_shamt_wrap");
        alu(2'b10, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'h1, 1'b0, "slt");
        alu(2'b10, 3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, "sltu");
        alu(2'b10, 3'b100, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, "xor");
        alu(2'b10, 3'b110, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, "or");
        alu(2'b10, 3'b111, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, "and");
        alu(2'b10, 3'b000, 7'b0000001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul");
        alu(2'b10, 3'b000, 7'b0000001, 32'h10000, 32'h10000, 32'h0, 1'b0, "mul_low_zero");
        alu(2'b11, 3'b000, 7'b1111111, 32'd10, 32'hFFFFFFFF, 32'd9, 1'b0, "addi_f7_ignored");
        alu(2'b11, 3'b001, 7'b0000001, 32'd1, 32'd1, 32'h0, 1'b1, "slli_bad_f7");
        alu(2'b11, 3'b101, 7'b0100000, 32'h80000000, 32'd1, 32'hC0000000, 1'b0, "srai");
        alu(2'b11, 3'b101, 7'b0100001, 32'h80000000, 32'd1, 32'h0, 1'b1, "srli_bad_f7");
        alu(2'b10, 3'b001, 7'b0000001, 32'd3, 32'd3, 32'h0, 1'b1, "mulh_illegal");
        settle();

        // Divide group (illegal with 1-cycle latency when the divider is not built)
        div_op(3'b100, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, "div_neg20_3");
        div_op(3'b110, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, "rem_neg20_3");
        div_op(3'b100, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, "div_20_neg3");
        div_op(3'b110, 32'd20, 32'hFFFFFFFD, 32'd2, "rem_20_neg3");
        div_op(3'b101, 32'd100, 32'd0, 32'hFFFFFFFF, "divu_by_zero");
        div_op(3'b111, 32'd100, 32'd0, 32'd100, "remu_by_zero");
        div_op(3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, "div_neg5_by_zero");
        div_op(3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, "rem_neg5_by_zero");
        div_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_overflow");
        div_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_overflow");
        div_op(3'b101, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, "divu_big");
        div_op(3'b111, 32'hFFFFFFFF, 32'd2, 32'd1, "remu_big");

        // Back-pressure: result held, no new accept while stalled
        out_ready = 1'b0;
        alu(2'b10, 3'b000, 7'b0000000, 32'd3, 32'd4, 32'd7, 1'b0, "add_stalled");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {31'b0, out_valid}, 32'h1);
            chk("stall_result", result, 32'd7);
            chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(2'b10, 3'b100, 7'b0000000, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFF00, 1'b0,
              "xor_on_release", w);
        chk("accept_on_release_wait", w, 32'h0);
        settle();

`ifdef ALU_DIV_EN
        // Reset in the middle of a division discards it.
        ALUOp    = 2'b10;
        funct3   = 3'b100;
        funct7   = 7'b0000001;
        a        = 32'hFFFFFFEC;
        b        = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("mid_div_busy", {31'b0, busy}, 32'h1);
        @(posedge clk);
        #1;
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_out_valid", {31'b0, out_valid}, 32'h0);
        chk("post_reset_busy", {31'b0, busy}, 32'h0);
        chk("post_reset_in_ready", {31'b0, in_ready}, 32'h1);
        settle();

        alu(2'b10, 3'b000, 7'b0000011, 32'd5, 32'd7, 32'h0, 1'b1, "illegal_f7_0000011");
        settle();
        settle();
        chk("scoreboard_drain", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
